dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
MA-stage load/store front end that drives the byte-enabled 1-read/1-write data RAM, which has a 1-cycle registered read address.
- Accepts one load or store request per handshake.
- Converts a byte address, size and store data into a word address, lane-shifted write data and 4-bit write enables.
- Takes the RAM read word one cycle later, then selects, aligns and sign- or zero-extends it into a response.
- Detects misaligned accesses.
- Holds the response under back-pressure.

Parameters:
DRWIDTH, 12, RAM word-address width; RAM holds 2**DRWIDTH 32-bit words.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
- req_unsigned  in  1  load zero-extends (LBU/LHU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned access
- ram_radr  out  DRWIDTH  RAM read word address
- ram_rdata  in  32  RAM read data, valid the cycle after ram_radr
- ram_wadr  out  DRWIDTH  RAM write word address
- ram_wdata  out  32  lane-aligned store data
- ram_wen  out  4  byte write enables

Behaviour:
- Clock and reset: one clock clk; rst_n is asynchronous and active-low.
- Reset values: state=IDLE; rsp_valid=0; rsp_err=0; hold register=0; all staged fields=0.
- Word address: ram_radr and ram_wadr both equal req_addr[DRWIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo the RAM size.
- Misalignment rules:
  - half access with addr[0]=1 is misaligned;
  - word access with addr[1:0]!=0 is misaligned.
- Store at acceptance, when aligned:
  - ram_wen: byte=1<<addr[1:0]; half=4'b0011<<addr[1:0]; word=4'b1111.
  - ram_wdata: the byte or half replicated across all lanes; word passed unchanged.
  - ram_wen=0 in every other cycle, and for misaligned stores.
- Load at acceptance: ram_radr is presented; staged fields capture {we, size, unsigned, addr[1:0], err}.
- req_ready = (state==IDLE) | (rsp_valid & rsp_ready). This allows back-to-back requests: one accepted per cycle with no bubble when rsp_ready=1.
- FSM:
  - IDLE: on accept, go to RESP.
  - RESP: rsp_valid=1. rsp_rdata is computed combinationally from ram_rdata:
    - lane select = addr[1:0] (byte) or addr[1] (half);
    - sign-extended unless unsigned.
    Transitions:
    - rsp_ready=1 with a new accept: stay in RESP.
    - rsp_ready=1 with no accept: go to IDLE.
    - rsp_ready=0: latch the computed rsp_rdata into the hold register and go to HOLD.
  - HOLD: rsp_valid=1; rsp_rdata comes from the hold register, so it is unaffected by RAM address changes. Transitions:
    - rsp_ready=1 with a new accept: go to RESP.
    - rsp_ready=1 with no accept: go to IDLE.
- rsp_err: valid with rsp_valid. A misaligned request performs no write, reads no data, and returns rsp_rdata=0 with rsp_err=1.
- Store followed by load to the same word in the next cycle: the load sees the new data. The write commits at the accept edge, before the RAM samples the read address. No forwarding logic is required.
- Reset mid-response: any in-flight response is dropped and no write is issued. A write already clocked into the RAM remains.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2;
  - FSM state localparams IDLE/RESP/HOLD.
- One natural sub-module, dmem_load_align: purely combinational, taking {ram_rdata, size, unsigned, addr[1:0]} and producing the 32-bit result.
- Store lane-enable and replication logic stays inline.

Test Plan:
1. Store word 0xDEADBEEF @0x10, then load word @0x10 -> ram_wen=4'hF, ram_wadr=4; load returns 0xDEADBEEF one cycle after accept, rsp_err=0.
2. Store byte 0x80 @0x13, then LB @0x13 and LBU @0x13:
   - store drives ram_wen=4'b1000 and ram_wdata=0x80808080;
   - LB returns 0xFFFFFF80;
   - LBU returns 0x00000080.
3. Store half 0x1234 @0x22, then LH @0x22 -> ram_wen=4'b1100; load returns 0x00001234. LH @0x20 returns the untouched lower half.
4. LH @0x21 and SW @0x06 -> both give rsp_err=1 and rsp_rdata=0; the store produces no ram_wen pulse.
5. Three back-to-back loads with rsp_ready=1 -> three consecutive rsp_valid cycles in order. Then hold rsp_ready=0 for 3 cycles while req_valid=1 -> req_ready=0 and rsp_rdata stable; release gives one response per ready.
6. Assert rst_n=0 during RESP -> rsp_valid=0 immediately (asynchronous); after release, state=IDLE and req_ready=1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the MA-stage data-memory front end.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RESP = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic [1:0] off;
        logic       err;
    } ma_stage_t;

    // Size 3 falls through to the word rule.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        if (size == SZ_BYTE) return 1'b0;
        if (size == SZ_HALF) return off[0];
        return off != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/response handshake bundle between the MA stage and the
// data-memory front end.
interface dmem_access_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned,
        output req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned,
        input  req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_load_align.sv
// Selects the addressed lane of a RAM word and sign/zero-extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  off,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{off, 3'b000} +: 8];
        lane_h = off[1] ? rdata[31:16] : rdata[15:0];
        unique case (size)
            SZ_BYTE: result = {{24{lane_b[7] & ~uns}}, lane_b};
            SZ_HALF: result = {{16{lane_h[15] & ~uns}}, lane_h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MA-stage load/store front end for a byte-enabled 1R/1W data RAM
// with a registered read address.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int DRWIDTH = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_access_ctrl_if.slave  bus,
    output logic [DRWIDTH-1:0] ram_radr,
    input  logic [31:0]        ram_rdata,
    output logic [DRWIDTH-1:0] ram_wadr,
    output logic [31:0]        ram_wdata,
    output logic [3:0]         ram_wen
);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    ma_stage_t   stg;
    logic [31:0] hold;
    logic        accept;
    logic        err_new;
    logic [1:0]  off;
    logic [31:0] ld_data;
    logic [31:0] rsp_data;
    logic        unused_addr;

    assign off         = bus.req_addr[1:0];
    assign unused_addr = ^bus.req_addr[31:DRWIDTH+2];
    assign err_new     = misaligned(bus.req_size, off);

    assign bus.rsp_valid = state != IDLE;
    assign bus.req_ready = (state == IDLE) |
                           (bus.rsp_valid & bus.rsp_ready);
    assign accept        = bus.req_valid & bus.req_ready;

    assign ram_radr = bus.req_addr[DRWIDTH+1:2];
    assign ram_wadr = bus.req_addr[DRWIDTH+1:2];

    // Writes are gated by rst_n so a reset never leaves a stray write.
    always_comb begin
        ram_wen   = 4'b0000;
        ram_wdata = bus.req_wdata;
        unique case (bus.req_size)
            SZ_BYTE: ram_wdata = {4{bus.req_wdata[7:0]}};
            SZ_HALF: ram_wdata = {2{bus.req_wdata[15:0]}};
            default: ;
        endcase
        if (accept & bus.req_we & ~err_new & rst_n) begin
            unique case (bus.req_size)
                SZ_BYTE: ram_wen = 4'b0001 << off;
                SZ_HALF: ram_wen = 4'b0011 << off;
                default: ram_wen = 4'b1111;
            endcase
        end
    end

    dmem_load_align u_align (
        .rdata  (ram_rdata),
        .size   (stg.size),
        .uns    (stg.uns),
        .off    (stg.off),
        .result (ld_data)
    );

    always_comb begin
        rsp_data = 32'h0;
        if (state == HOLD)
            rsp_data = hold;
        else if (state == RESP && !stg.we && !stg.err)
            rsp_data = ld_data;
    end

    assign bus.rsp_rdata = rsp_data;
    assign bus.rsp_err   = stg.err & bus.rsp_valid;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = RESP;
            RESP, HOLD: begin
                if (!bus.rsp_ready) state_nxt = HOLD;
                else if (accept)    state_nxt = RESP;
                else                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            stg   <= '0;
            hold  <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                stg.we   <= bus.req_we;
                stg.size <= bus.req_size;
                stg.uns  <= bus.req_unsigned;
                stg.off  <= off;
                stg.err  <= err_new;
            end
            if (state == RESP && !bus.rsp_ready)
                hold <= rsp_data;
        end
    end

endmodule
